bft_pkt_rr_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter sharing one BFT switch output link (e.g. u0 uplink) between N_IN input streams.
//  A grant is held from first flit to wlast, so flits of different packets never interleave on the link.

---
 rtl/bft_pkt_rr_arbiter_if.sv | 25 ++
 rtl/bft_pkt_rr_arbiter.sv | 106 ++++++++++
 tb/tb_bft_pkt_rr_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bft_pkt_rr_arbiter_if.sv
// bft_pkt_rr_arbiter_if: flit bus between N_IN input streams, the arbiter and the shared output link.
// The slave modport is the arbiter's view; the master modport is the upstream/downstream side.
interface bft_pkt_rr_arbiter_if #(
    parameter int N_IN = 2,
    parameter int W    = 35
);
    logic [N_IN*W-1:0] s_wdata;
    logic [N_IN-1:0]   s_wvalid;
    logic [N_IN-1:0]   s_wlast;
    logic [N_IN-1:0]   s_wready;
    logic [W-1:0]      m_wdata;
    logic              m_wvalid;
    logic              m_wlast;
    logic              m_wready;

    modport slave (
        input  s_wdata, s_wvalid, s_wlast, m_wready,
        output s_wready, m_wdata, m_wvalid, m_wlast
    );

    modport master (
        output s_wdata, s_wvalid, s_wlast, m_wready,
        input  s_wready, m_wdata, m_wvalid, m_wlast
    );
endinterface

// File: rtl/bft_pkt_rr_arbiter.sv
// bft_pkt_rr_arbiter: packet-atomic round-robin arbiter with a registered output stage.
// Optional ARB_GRANT_STATS_EN adds saturating per-stream packet grant counters on grant_cnt.
module bft_pkt_rr_arbiter #(
    parameter int N_IN = 2,
    parameter int D_W  = 32,
    parameter int A_W  = 3,
    localparam int W   = A_W + D_W,
    localparam int GW  = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    bft_pkt_rr_arbiter_if.slave  bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
`ifdef ARB_GRANT_STATS_EN
    ,
    output logic [N_IN*16-1:0]   grant_cnt
`endif
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t        r_state, w_state;
    logic [GW-1:0] r_ptr, r_gid, w_ptr, w_gid, w_pick, w_idx;
    logic [W-1:0]  r_data;
    logic          r_valid, r_last;
    logic          w_req, w_open, w_xfer;
    logic [W-1:0]  w_in [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign w_in[i] = bus.s_wdata[i*W +: W];
    end

    // Scan downward so the requester closest to r_ptr is the last (winning) assignment
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_idx = GW'((int'(r_ptr) + k) % N_IN);
            if (bus.s_wvalid[w_idx]) w_pick = w_idx;
        end
    end

    assign w_req        = |bus.s_wvalid;
    assign w_open       = ce && r_state == LOCK && (!r_valid || bus.m_wready);
    assign w_xfer       = w_open && bus.s_wvalid[r_gid];
    assign bus.s_wready = w_open ? N_IN'(1) << r_gid : '0;

    always_comb begin
        w_state = r_state;
        w_gid   = r_gid;
        w_ptr   = r_ptr;
        if (r_state == IDLE && w_req) begin
            w_state = LOCK;
            w_gid   = w_pick;
        end
        if (w_xfer && bus.s_wlast[r_gid]) begin
            w_state = IDLE;
            w_ptr   = (r_gid == GW'(N_IN - 1)) ? '0 : r_gid + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gid   <= '0;
            r_ptr   <= '0;
        end else if (ce) begin
            r_state <= w_state;
            r_gid   <= w_gid;
            r_ptr   <= w_ptr;
        end
    end

    // Load and drain in the same cycle keeps a packet at one flit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= w_in[r_gid];
            r_last  <= bus.s_wlast[r_gid];
            r_valid <= 1'b1;
        end else if (ce && bus.m_wready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.m_wdata  = r_data;
    assign bus.m_wlast  = r_last;
    assign bus.m_wvalid = r_valid;
    assign grant_id     = r_gid;
    assign busy         = r_state == LOCK;

`ifdef ARB_GRANT_STATS_EN
    for (genvar i = 0; i < N_IN; i++) begin : g_cnt
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_cnt <= '0;
            else if (ce && r_state == IDLE && w_req && w_pick == GW'(i) && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 1'b1;
        end
        assign grant_cnt[i*16 +: 16] = r_cnt;
    end
`endif
endmodule

// File: tb/tb_bft_pkt_rr_arbiter.sv
// tb_bft_pkt_rr_arbiter: randomized bench for a 4-stream arbiter against a packet-level model,
// plus a directed 2-stream ordering run (grant counters checked when ARB_GRANT_STATS_EN is set).
module tb_bft_pkt_rr_arbiter;
    localparam int W = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    bft_pkt_rr_arbiter_if #(.N_IN(4), .W(W)) b4 ();
    bft_pkt_rr_arbiter_if #(.N_IN(2), .W(W)) b2 ();

    logic       rst4_n, ce4, busy4, rst2_n, ce2, busy2;
    logic [1:0] gid4;
    logic [0:0] gid2;
`ifdef ARB_GRANT_STATS_EN
    logic [63:0] cnt4;
    logic [31:0] cnt2;
`endif

    bft_pkt_rr_arbiter #(.N_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .ce(ce4), .bus(b4.slave), .grant_id(gid4), .busy(busy4)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(cnt4)
`endif
    );

    bft_pkt_rr_arbiter #(.N_IN(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .ce(ce2), .bus(b2.slave), .grant_id(gid2), .busy(busy2)
`ifdef ARB_GRANT_STATS_EN
        , .grant_cnt(cnt2)
`endif
    );

    // upstream packet generators for the 4-stream DUT
    int         fidx[4], plen[4], pseq[4], budget[4];
    logic [W-1:0] cur[4];
    int         pv, pr, pc;
    // reference model: owner (-1 when no packet is granted), pointer, last grant, output register
    int         mo, mp, mg;
    logic       mv, ml;
    logic [W-1:0] md;
    logic       pbusy;
    int         gq[$];

    task automatic new_flit(input int i);
        cur[i] = {2'(i), 8'(pseq[i]), 3'(fidx[i]), 22'($urandom)};
    endtask

    task automatic gen_reset();
        for (int i = 0; i < 4; i++) begin
            fidx[i] = 0;
            plen[i] = $urandom_range(1, 4);
            new_flit(i);
        end
    endtask

    task automatic model_reset();
        mo = -1; mp = 0; mg = 0; mv = 1'b0; ml = 1'b0; md = '0;
    endtask

    task automatic tick4();
        logic [3:0] er;
        int j;
        logic lst;
        for (int i = 0; i < 4; i++) begin
            b4.s_wvalid[i] = budget[i] > 0 && $urandom_range(99) < pv;
            b4.s_wlast[i]  = fidx[i] == plen[i] - 1;
            b4.s_wdata[i*W +: W] = cur[i];
        end
        b4.m_wready = $urandom_range(99) < pr;
        ce4 = $urandom_range(99) < pc;
        @(negedge clk);
        if (!rst4_n) begin
            model_reset();
            gen_reset();
            check("rst_wdata", b4.m_wdata, 0);
            check("rst_wlast", b4.m_wlast, 0);
            check("rst_grant_id", gid4, 0);
        end
        if (busy4 && !pbusy) gq.push_back(int'(gid4));
        pbusy = busy4;
        er = (ce4 && mo >= 0 && (!mv || b4.m_wready)) ? 4'(1 << mo) : 4'b0;
        check("s_wready", b4.s_wready, er);
        check("m_wvalid", b4.m_wvalid, mv);
        if (mv) begin
            check("m_wdata", b4.m_wdata, md);
            check("m_wlast", b4.m_wlast, ml);
        end
        check("busy", busy4, mo >= 0);
        if (mo >= 0) check("grant_id", gid4, mg);
        if (rst4_n && ce4) begin
            if (mo >= 0 && er[mo] && b4.s_wvalid[mo]) begin
                lst = fidx[mo] == plen[mo] - 1;
                md = cur[mo]; ml = lst; mv = 1'b1;
                if (lst) begin
                    fidx[mo] = 0; plen[mo] = $urandom_range(1, 4); pseq[mo]++; budget[mo]--;
                end else fidx[mo]++;
                new_flit(mo);
                if (lst) begin
                    mp = (mo + 1) % 4;
                    mo = -1;
                end
            end else begin
                if (b4.m_wready) mv = 1'b0;
                if (mo < 0) begin
                    j = -1;
                    for (int k = 0; k < 4; k++) if (j < 0 && b4.s_wvalid[(mp + k) % 4]) j = (mp + k) % 4;
                    if (j >= 0) begin
                        mo = j; mg = j;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        for (int t = 0; t < 60 && !busy4; t++) tick4();
        check(tag, busy4, 1);
    endtask

    int ge[3] = '{3, 0, 2};
    int f2[2], pk2[2];
    int seen, lastcyc;
    int g2q[$];
    logic pb2;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst4_n = 1'b0; rst2_n = 1'b0; ce2 = 1'b0; ce4 = 1'b0;
        b2.s_wvalid = '0; b2.s_wlast = '0; b2.s_wdata = '0; b2.m_wready = 1'b0;
        pbusy = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            budget[i] = 2; pseq[i] = 0;
        end
        gen_reset();
        pv = 100; pr = 50; pc = 100;
        repeat (3) tick4();
        rst4_n = 1'b1;
        for (int i = 0; i < 4; i++) budget[i] = 0;
        pr = 100;
        repeat (4) tick4();
        budget[3] = 1;
        repeat (8) tick4();
        budget[0] = 1; budget[2] = 1;
        repeat (16) tick4();
        check("n_grants", gq.size(), 3);
        for (int k = 0; k < 3 && k < gq.size(); k++) check("grant_order", gq[k], ge[k]);
        for (int i = 0; i < 4; i++) budget[i] = 1000;
        pv = 70; pr = 60; pc = 90;
        repeat (300) tick4();
        wait_busy("busy_before_freeze");
        pc = 0;
        repeat (3) tick4();
        pc = 100;
        repeat (20) tick4();
        wait_busy("busy_before_reset");
        rst4_n = 1'b0;
        tick4();
        rst4_n = 1'b1;
        pc = 90;
        repeat (200) tick4();

        // 2-stream run: 3-flit packets, 5 per stream, downstream always ready
        f2 = '{0, 0}; pk2 = '{0, 0}; seen = 0; lastcyc = 0; pb2 = 1'b0;
        ce2 = 1'b1;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int cyc = 0; cyc < 200 && seen < 30; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                b2.s_wvalid[i] = pk2[i] < 5;
                b2.s_wlast[i]  = f2[i] == 2;
                b2.s_wdata[i*W +: W] = W'(i * 4 + f2[i]);
            end
            b2.m_wready = 1'b1;
            @(negedge clk);
            if (busy2 && !pb2) g2q.push_back(int'(gid2));
            pb2 = busy2;
            if (b2.m_wvalid) begin
                check("order2", b2.m_wdata, ((seen / 3) % 2) * 4 + seen % 3);
                if (seen > 0) check("gap2", cyc - lastcyc, (seen % 3 == 0) ? 2 : 1);
                lastcyc = cyc;
                seen++;
            end
            for (int i = 0; i < 2; i++) begin
                if (b2.s_wready[i] && b2.s_wvalid[i]) begin
                    if (f2[i] == 2) begin
                        f2[i] = 0; pk2[i]++;
                    end else f2[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
        check("flits2", seen, 30);
        check("grants2", g2q.size(), 10);
        for (int k = 0; k < g2q.size(); k++) check("grant2_id", g2q[k], k % 2);
`ifdef ARB_GRANT_STATS_EN
        check("grant_cnt", cnt2, {16'd5, 16'd5});
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
